x_400_operand_loader: RTL and testbench

- Upstream stage of the 400-bit mod-461 reducer (x_400_mod_461).
- Assembles a 400-bit operand X from a word-serial valid/ready stream.
- Presents X to the combinational reducer with an x_valid/x_ready handshake.
- Holds X stable until the reducer side accepts it. Does not instantiate the reducer itself.

---
 rtl/mod461_pkg.sv | 23 ++
 rtl/x_400_operand_loader.sv | 106 ++++++++++
 tb/tb_x_400_operand_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod461_pkg.sv
// Shared constants and types for the mod-461 datapath: the operand loader,
// the 400-bit reducer and later residue-consumer stages.
//   X_W     : operand width seen by the reducer
//   R_W     : residue width
//   MOD_461 : modulus
//   beats() : words needed to fill an X_W operand at a given word width
//   ld_state_t : loader FSM states
package mod461_pkg;

  localparam int X_W = 400;
  localparam int R_W = 9;
  localparam logic [R_W-1:0] MOD_461 = 9'd461;

  function automatic int beats(input int w);
    return (X_W + w - 1) / w;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } ld_state_t;

endpackage

// File: rtl/x_400_operand_loader.sv
// Operand loader feeding the 400-bit mod-461 reducer.
// Assembles X from a word-serial valid/ready stream, then presents it with
// an x_valid/x_ready handshake and holds it until it is consumed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    operand word stream
//   in_last             final word of the operand (qualified by in_valid)
//   in_ready            loader accepts a word this cycle
//   X [X_W:1]           assembled operand, bit 1 is the LSB
//   x_valid/x_ready     operand handshake towards the reducer
//   short_op            X was terminated early by in_last (valid with x_valid)
//
// Build option: define MSW_FIRST_EN for most-significant-word-first streams
// (X shifts left by W_IN per word). Default is LSW-first slot-indexed writes.
//
// state   | meaning
// COLLECT | accepting words, in_ready=1, x_valid=0
// HOLD    | X complete and frozen, in_ready=0, x_valid=1
module x_400_operand_loader #(
  parameter int W_IN = 16,
  parameter int X_W  = 400
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W_IN-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [X_W:1]    X,
  output logic            x_valid,
  input  logic            x_ready,
  output logic            short_op
);
  import mod461_pkg::*;

  localparam int BEATS = beats(W_IN);
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  ld_state_t     state;
  logic [CW-1:0] cnt;
  logic [X_W:1]  x_next;
  logic          accept;

  assign accept = in_valid && in_ready;

  // X is zero at frame start, so unwritten slots (short frame) stay zero.
  always_comb begin
    x_next = X;
`ifdef MSW_FIRST_EN
    x_next = {X[X_W-W_IN:1], in_data};
`else
    // Bits of the last slot that fall above X_W simply have no target.
    for (int i = 0; i < X_W; i++) begin
      if (i / W_IN == int'(cnt)) x_next[i+1] = in_data[i % W_IN];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      cnt      <= '0;
      X        <= '0;
      in_ready <= 1'b1;
      x_valid  <= 1'b0;
      short_op <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            X <= x_next;
            if (cnt == LAST_BEAT || in_last) begin
              state    <= HOLD;
              in_ready <= 1'b0;
              x_valid  <= 1'b1;
              short_op <= (cnt != LAST_BEAT);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (x_ready) begin
            state    <= COLLECT;
            cnt      <= '0;
            X        <= '0;
            in_ready <= 1'b1;
            x_valid  <= 1'b0;
            short_op <= 1'b0;
          end
        end
        default: begin
          state    <= COLLECT;
          cnt      <= '0;
          X        <= '0;
          in_ready <= 1'b1;
          x_valid  <= 1'b0;
          short_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_400_operand_loader.sv
module tb_x_400_operand_loader;
  localparam int W  = 16;
  localparam int XW = 400;
  localparam int NB = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [XW:1]   X;
  logic          x_valid;
  logic          x_ready;
  logic          short_op;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] words [NB];

  x_400_operand_loader #(.W_IN(W), .X_W(XW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .X(X), .x_valid(x_valid),
    .x_ready(x_ready), .short_op(short_op)
  );

  always #5 clk = ~clk;

  // Operand value implied by the first n words of the stream.
  function automatic logic [XW-1:0] model_x(input int n);
    logic [XW+W-1:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++) begin
`ifdef MSW_FIRST_EN
      acc = ((acc << W) | (XW+W)'(words[k])) & {{W{1'b0}}, {XW{1'b1}}};
`else
      acc = acc | ((XW+W)'(words[k]) << (k * W));
`endif
    end
    return acc[XW-1:0];
  endfunction

  // Same operand reduced mod 461 by Horner's rule on the words.
  function automatic longint model_mod(input int n);
    longint r;
    r = 0;
`ifdef MSW_FIRST_EN
    for (int k = 0; k < n; k++) r = (r * 65536 + longint'(words[k])) % 461;
`else
    for (int k = n - 1; k >= 0; k--) r = (r * 65536 + longint'(words[k])) % 461;
`endif
    return r;
  endfunction

  task automatic check_idle(input string name);
    vectors++;
    if (in_ready !== 1'b1 || x_valid !== 1'b0 || short_op !== 1'b0 || X !== '0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b x_valid=%b short_op=%b X=%h required 1 0 0 0",
               name, in_ready, x_valid, short_op, X);
    end
  endtask

  // Stream n words; in_last on word last_at (-1 = never). Optional idle gaps
  // with junk on in_data/in_last and random x_ready, which COLLECT ignores.
  task automatic send_frame(input string name, input int n, input int last_at, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = W'($urandom);
          in_last  = 1'($urandom);
          x_ready  = 1'($urandom);
        end
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || x_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s beat %0d: in_ready=%b x_valid=%b required 1 0", name, k, in_ready, x_valid);
      end
      in_valid = 1'b1;
      in_data  = words[k];
      in_last  = (k == last_at);
      x_ready  = gaps ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    x_ready  = 1'b0;
  endtask

  task automatic check_hold(input string name, input int n, input bit exp_short);
    logic [XW-1:0] ex;
    ex = model_x(n);
    vectors++;
    if (x_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: x_valid=%b in_ready=%b required 1 0", name, x_valid, in_ready);
    end
    vectors++;
    if (X !== ex) begin
      errors++;
      $display("FAIL %s X: got %h required %h", name, X, ex);
    end
    vectors++;
    if (short_op !== exp_short) begin
      errors++;
      $display("FAIL %s short_op: got %b required %b", name, short_op, exp_short);
    end
  endtask

  task automatic consume(input string name);
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    check_idle({name, " after consume"});
  endtask

  task automatic check_mod(input string name, input int n);
    longint got;
    longint ex;
    got = longint'(X % 400'd461);
    ex  = model_mod(n);
    vectors++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s residue: got %0d required %0d", name, got, ex);
    end
  endtask

  task automatic clear_words();
    for (int k = 0; k < NB; k++) words[k] = '0;
  endtask

  task automatic random_words();
    for (int k = 0; k < NB; k++) words[k] = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; x_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset asserted");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset released");
  endtask

  task automatic test_single_low();
    clear_words();
    words[0] = 16'h0001;
    send_frame("low_word", NB, -1, 1'b0);
    check_hold("low_word", NB, 1'b0);
    check_mod("low_word", NB);
    consume("low_word");
  endtask

  task automatic test_top_word();
    clear_words();
    words[24] = 16'hFFFF;
    send_frame("top_word", NB, -1, 1'b0);
    check_hold("top_word", NB, 1'b0);
    check_mod("top_word", NB);
    consume("top_word");
  endtask

  task automatic test_backpressure();
    logic [XW-1:0] ex;
    random_words();
    send_frame("bp", NB, -1, 1'b0);
    check_hold("bp", NB, 1'b0);
    ex = model_x(NB);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (X !== ex || in_ready !== 1'b0 || x_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp stall %0d: X=%h in_ready=%b x_valid=%b required X=%h 0 1",
                 c, X, in_ready, x_valid, ex);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume("bp");
    // a junk word taken during the stall would shift this frame
    random_words();
    send_frame("bp next", NB, -1, 1'b0);
    check_hold("bp next", NB, 1'b0);
    consume("bp next");
  endtask

  task automatic test_short();
    clear_words();
`ifdef MSW_FIRST_EN
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
`else
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
`endif
    send_frame("short3", 3, 2, 1'b0);
    check_hold("short3", 3, 1'b1);
    vectors++;
`ifdef MSW_FIRST_EN
    if (X !== 400'h0AAAABBBBCCCC) begin
`else
    if (X !== 400'h333322221111) begin
`endif
      errors++;
      $display("FAIL short3 literal: got %h", X);
    end
    consume("short3");
    random_words();
    send_frame("after short", NB, -1, 1'b0);
    check_hold("after short", NB, 1'b0);
    consume("after short");
  endtask

  task automatic test_last_on_final();
    random_words();
    send_frame("last_final", NB, NB - 1, 1'b0);
    check_hold("last_final", NB, 1'b0);
    consume("last_final");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 12; f++) begin
      int n;
      random_words();
      n = $urandom_range(1, NB);
      send_frame("rand", n, (n == NB && $urandom_range(0, 1) == 0) ? -1 : n - 1, 1'b1);
      check_hold("rand", n, n < NB);
      check_mod("rand", n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume("rand");
    end
  endtask

  task automatic test_reset_mid();
    random_words();
    send_frame("mid", 10, -1, 1'b0);
    rst_n = 1'b0;
    #2;
    check_idle("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid released");
    random_words();
    send_frame("post reset", NB, -1, 1'b0);
    check_hold("post reset", NB, 1'b0);
    consume("post reset");
  endtask

  initial begin
    test_reset();
    test_single_low();
    test_top_word();
    test_backpressure();
    test_short();
    test_last_on_final();
    test_random_frames();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
